// File: rtl/daq_stream_arbiter_if.sv
// Stream bundle shared by the two DAQ counter inputs and the merged DMA output.
// Signals: tvalid/tready handshake, tdata payload, tstrb byte strobes, tlast
// end of packet, tid source channel (driven only on the merged master side).
interface daq_stream_arbiter_if #(
    parameter int W = 64
);
    logic           tvalid;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           tid;
    logic           tready;

    modport master (output tvalid, tdata, tstrb, tlast, tid, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, tid, output tready);
endinterface

// File: rtl/daq_stream_arbiter.sv
// Packet-locked round-robin merge of CNT0 (s00) and CNT1 (s01) onto one registered stream (m00).
// Latency: 2 cycles from IDLE with a valid source to first m00.tvalid; 1 beat/cycle sustained.
// Backpressure: source tready = granted & (output register empty or draining); held beat stays stable.
//
// Ports: CLK, Reset (sync, active high); s00/s01 slave streams; m00 master stream with tid tag;
// I_EN0/I_EN1 grant eligibility; O_GRANT one-hot grant (00 idle); O_BUSY grant or output pending.
// Optional: define DAQ_ARB_STATS_EN to add O_PKT_CNT0/O_PKT_CNT1 per-channel delivered-packet counters.
module daq_stream_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter bit C_LAST_GRANT_INIT  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    daq_stream_arbiter_if.slave   s00,
    daq_stream_arbiter_if.slave   s01,
    daq_stream_arbiter_if.master  m00,
    input  logic                  I_EN0,
    input  logic                  I_EN1,
    output logic [1:0]            O_GRANT,
    output logic                  O_BUSY
`ifdef DAQ_ARB_STATS_EN
    ,
    output logic [31:0]           O_PKT_CNT0,
    output logic [31:0]           O_PKT_CNT1
`endif
);
    localparam int SW = C_AXIS_TDATA_WIDTH / 8;

    // Encoding chosen so the state value is directly the one-hot grant.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t                        state, state_nxt;
    logic                          last_grant, last_grant_nxt;
    logic                          out_vld;
    logic [C_AXIS_TDATA_WIDTH-1:0] out_dat;
    logic [SW-1:0]                 out_strb;
    logic                          out_last;
    logic                          out_tid;

    logic out_free, rdy0, rdy1, acc0, acc1, acc_last, req0, req1;

    assign out_free = ~out_vld | m00.tready;
    assign rdy0     = (state == GNT0) & out_free;
    assign rdy1     = (state == GNT1) & out_free;
    assign acc0     = s00.tvalid & rdy0;
    assign acc1     = s01.tvalid & rdy1;
    assign acc_last = (acc0 & s00.tlast) | (acc1 & s01.tlast);
    assign req0     = s00.tvalid & I_EN0;
    assign req1     = s01.tvalid & I_EN1;

    // Re-arbitrating on the tlast beat itself is what removes the bubble
    // between back-to-back packets. last_grant = 1 means channel 0 wins a tie.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (state == IDLE || acc_last) begin
            if (req0 && (!req1 || last_grant)) begin
                state_nxt      = GNT0;
                last_grant_nxt = 1'b0;
            end else if (req1) begin
                state_nxt      = GNT1;
                last_grant_nxt = 1'b1;
            end else begin
                state_nxt      = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= C_LAST_GRANT_INIT;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_strb   <= '0;
            out_last   <= 1'b0;
            out_tid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (acc0) begin
                out_vld  <= 1'b1;
                out_dat  <= s00.tdata;
                out_strb <= s00.tstrb;
                out_last <= s00.tlast;
                out_tid  <= 1'b0;
            end else if (acc1) begin
                out_vld  <= 1'b1;
                out_dat  <= s01.tdata;
                out_strb <= s01.tstrb;
                out_last <= s01.tlast;
                out_tid  <= 1'b1;
            end else if (m00.tready) begin
                out_vld  <= 1'b0;
            end
        end
    end

    assign s00.tready = rdy0;
    assign s01.tready = rdy1;
    assign m00.tvalid = out_vld;
    assign m00.tdata  = out_dat;
    assign m00.tstrb  = out_strb;
    assign m00.tlast  = out_last;
    assign m00.tid    = out_tid;
    assign O_GRANT    = state;
    assign O_BUSY     = (state != IDLE) | out_vld;

`ifdef DAQ_ARB_STATS_EN
    logic [31:0] pkt_cnt0, pkt_cnt1;
    logic        pkt_done;

    // Counted at delivery to the DMA side, not at acceptance from the source.
    assign pkt_done = out_vld & m00.tready & out_last;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (pkt_done) begin
            if (out_tid) pkt_cnt1 <= pkt_cnt1 + 32'd1;
            else         pkt_cnt0 <= pkt_cnt0 + 32'd1;
        end
    end

    assign O_PKT_CNT0 = pkt_cnt0;
    assign O_PKT_CNT1 = pkt_cnt1;
`endif
endmodule

// File: tb/tb_daq_stream_arbiter.sv
// Bench for daq_stream_arbiter: directed vector table plus stream sequences
// (round robin, backpressure, enable drop, reset mid-packet, optional stats).
module tb_daq_stream_arbiter;
    localparam int W = 64;

    logic CLK = 1'b0;
    logic Reset;
    logic I_EN0, I_EN1;
    logic [1:0] O_GRANT;
    logic O_BUSY;
`ifdef DAQ_ARB_STATS_EN
    logic [31:0] O_PKT_CNT0, O_PKT_CNT1;
`endif

    always #5 CLK = ~CLK;

    daq_stream_arbiter_if #(.W(W)) s00 ();
    daq_stream_arbiter_if #(.W(W)) s01 ();
    daq_stream_arbiter_if #(.W(W)) m00 ();

    daq_stream_arbiter #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_LAST_GRANT_INIT(1'b1)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .s00(s00),
        .s01(s01),
        .m00(m00),
        .I_EN0(I_EN0),
        .I_EN1(I_EN1),
        .O_GRANT(O_GRANT),
        .O_BUSY(O_BUSY)
`ifdef DAQ_ARB_STATS_EN
        ,
        .O_PKT_CNT0(O_PKT_CNT0),
        .O_PKT_CNT1(O_PKT_CNT1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       s0v; logic [7:0] s0d; logic s0l;
        logic       s1v; logic [7:0] s1d; logic s1l;
        logic       en0, en1, mrdy;
        logic       ev;  logic [7:0] ed;  logic el; logic et;
        logic [1:0] eg;
        logic       er0, er1, eb;
    } vec_t;

    vec_t tbl[15];

    // ---------------- stream source model + scoreboard ----------------
    typedef struct packed {
        logic [7:0]  strb;
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    logic  tid_log[$];
    int    idx[2];
    int    src_lim[2];
    logic  src_on[2];
    int    pkt_len;
    int    cyc;
    int    bp_start, bp_len;
    int    en_drop_at;
    int    stall_cnt, gap_cnt;
    logic  gap_en, seen_vld, stalled_prev;
    beat_t snap;
    logic  snap_tid;

    task automatic drive_src();
        m00.tready = !(bp_len > 0 && cyc >= bp_start && cyc < bp_start + bp_len);
        s00.tvalid = src_on[0] && (idx[0] < src_lim[0]);
        s00.tdata  = {48'd0, 8'd0, 8'(idx[0])};
        s00.tstrb  = 8'(idx[0] * 3 + 1);
        s00.tlast  = (idx[0] % pkt_len) == pkt_len - 1;
        s00.tid    = 1'b0;
        s01.tvalid = src_on[1] && (idx[1] < src_lim[1]);
        s01.tdata  = {48'd0, 8'd1, 8'(idx[1])};
        s01.tstrb  = 8'(idx[1] * 5 + 2);
        s01.tlast  = (idx[1] % pkt_len) == pkt_len - 1;
        s01.tid    = 1'b0;
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); tid_log.delete();
        idx[0] = 0; idx[1] = 0;
        src_lim[0] = 1000; src_lim[1] = 1000;
        cyc = 0; bp_len = 0; bp_start = 0; en_drop_at = -1;
        stall_cnt = 0; gap_cnt = 0; gap_en = 0; seen_vld = 0; stalled_prev = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        src_on[0] = 1'b0; src_on[1] = 1'b0;
        I_EN0 = 1'b1; I_EN1 = 1'b1;
        pkt_len = 4;
        clear_model();
        drive_src();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Reset = 1'b0;
    endtask

    // Caller sits at posedge+1; each iteration scores at negedge and updates sources after the edge.
    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            logic  hs0, hs1, mhs;
            beat_t e;
            @(negedge CLK);
            hs0 = s00.tvalid & s00.tready;
            hs1 = s01.tvalid & s01.tready;
            mhs = m00.tvalid & m00.tready;
            if (hs0) q0.push_back('{s00.tstrb, s00.tlast, s00.tdata});
            if (hs1) q1.push_back('{s01.tstrb, s01.tlast, s01.tdata});
            if (mhs) begin
                if ((m00.tid == 1'b0 && q0.size() == 0) || (m00.tid == 1'b1 && q1.size() == 0)) begin
                    n_chk++;
                    $display("FAIL sb_extra_beat: got beat %0h on tid %0d, required none", m00.tdata, m00.tid);
                end else begin
                    e = (m00.tid == 1'b0) ? q0.pop_front() : q1.pop_front();
                    chk("sb_data", m00.tdata, e.data);
                    chk("sb_last", 64'(m00.tlast), 64'(e.last));
                    chk("sb_strb", 64'(m00.tstrb), 64'(e.strb));
                end
                tid_log.push_back(m00.tid);
            end
            if (gap_en) begin
                if (m00.tvalid) seen_vld = 1'b1;
                else if (seen_vld) gap_cnt++;
            end
            if (m00.tvalid && !m00.tready) begin
                stall_cnt++;
                chk("stall_s00_rdy", 64'(s00.tready), 64'd0);
                chk("stall_s01_rdy", 64'(s01.tready), 64'd0);
                if (stalled_prev) begin
                    chk("stall_hold_data", m00.tdata, snap.data);
                    chk("stall_hold_last", 64'(m00.tlast), 64'(snap.last));
                    chk("stall_hold_tid", 64'(m00.tid), 64'(snap_tid));
                end
                snap = '{m00.tstrb, m00.tlast, m00.tdata};
                snap_tid = m00.tid;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
            if (hs0) idx[0]++;
            if (hs1) idx[1]++;
            if (en_drop_at >= 0 && idx[0] >= en_drop_at) I_EN0 = 1'b0;
            drive_src();
        end
    endtask

    initial begin
        tbl[0]  = '{0,8'h00,0, 1,8'h01,0, 1,1,1, 0,8'h00,0,0, 2'b10, 0,1,1};
        tbl[1]  = '{0,8'h00,0, 1,8'h01,0, 1,1,1, 1,8'h01,0,1, 2'b10, 0,1,1};
        tbl[2]  = '{0,8'h00,0, 1,8'h02,0, 1,1,1, 1,8'h02,0,1, 2'b10, 0,1,1};
        tbl[3]  = '{0,8'h00,0, 1,8'h03,1, 1,1,1, 1,8'h03,1,1, 2'b10, 0,1,1};
        tbl[4]  = '{0,8'h00,0, 0,8'h00,0, 1,1,1, 0,8'h00,0,0, 2'b10, 0,1,1};
        tbl[5]  = '{1,8'h10,1, 0,8'h00,0, 1,1,1, 0,8'h00,0,0, 2'b10, 0,1,1};
        tbl[6]  = '{1,8'h10,1, 1,8'h04,1, 1,1,1, 1,8'h04,1,1, 2'b01, 1,0,1};
        tbl[7]  = '{1,8'h10,1, 1,8'h05,1, 1,1,1, 1,8'h10,1,0, 2'b10, 0,1,1};
        tbl[8]  = '{1,8'h11,1, 1,8'h05,1, 1,1,0, 1,8'h10,1,0, 2'b10, 0,0,1};
        tbl[9]  = '{1,8'h11,1, 1,8'h05,1, 1,1,0, 1,8'h10,1,0, 2'b10, 0,0,1};
        tbl[10] = '{1,8'h11,1, 1,8'h05,1, 1,1,1, 1,8'h05,1,1, 2'b01, 1,0,1};
        tbl[11] = '{1,8'h11,1, 1,8'h06,1, 0,0,1, 1,8'h11,1,0, 2'b00, 0,0,1};
        tbl[12] = '{1,8'h11,1, 1,8'h06,1, 0,0,1, 0,8'h00,0,0, 2'b00, 0,0,0};
        tbl[13] = '{1,8'h11,1, 1,8'h06,1, 0,0,1, 0,8'h00,0,0, 2'b00, 0,0,0};
        tbl[14] = '{1,8'h11,1, 1,8'h06,1, 0,1,1, 0,8'h00,0,0, 2'b10, 0,1,1};

        // ---- reset held 3 cycles with both sources valid ----
        Reset = 1'b1;
        I_EN0 = 1'b1; I_EN1 = 1'b1;
        pkt_len = 4;
        clear_model();
        src_on[0] = 1'b1; src_on[1] = 1'b1;
        drive_src();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("rst_m_vld", 64'(m00.tvalid), 64'd0);
            chk("rst_m_data", m00.tdata, 64'd0);
            chk("rst_m_strb", 64'(m00.tstrb), 64'd0);
            chk("rst_m_last", 64'(m00.tlast), 64'd0);
            chk("rst_m_tid", 64'(m00.tid), 64'd0);
            chk("rst_grant", 64'(O_GRANT), 64'd0);
            chk("rst_busy", 64'(O_BUSY), 64'd0);
            chk("rst_s00_rdy", 64'(s00.tready), 64'd0);
            chk("rst_s01_rdy", 64'(s01.tready), 64'd0);
        end
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_grant", 64'(O_GRANT), 64'd1);
        chk("post_rst_s00_rdy", 64'(s00.tready), 64'd1);
        @(posedge CLK); #1;
        chk("post_rst_first_vld", 64'(m00.tvalid), 64'd1);
        chk("post_rst_first_tid", 64'(m00.tid), 64'd0);
        chk("post_rst_first_data", m00.tdata, 64'h0000);

        // ---- directed vector table ----
        do_reset();
        for (int i = 0; i < 15; i++) begin
            s00.tvalid = tbl[i].s0v; s00.tdata = {56'd0, tbl[i].s0d}; s00.tlast = tbl[i].s0l;
            s00.tstrb  = 8'hFF;      s00.tid = 1'b0;
            s01.tvalid = tbl[i].s1v; s01.tdata = {56'd0, tbl[i].s1d}; s01.tlast = tbl[i].s1l;
            s01.tstrb  = 8'hFF;      s01.tid = 1'b0;
            I_EN0 = tbl[i].en0; I_EN1 = tbl[i].en1; m00.tready = tbl[i].mrdy;
            @(posedge CLK); #1;
            chk($sformatf("vec%0d_vld", i), 64'(m00.tvalid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), m00.tdata, {56'd0, tbl[i].ed});
                chk($sformatf("vec%0d_last", i), 64'(m00.tlast), 64'(tbl[i].el));
                chk($sformatf("vec%0d_tid", i), 64'(m00.tid), 64'(tbl[i].et));
            end
            chk($sformatf("vec%0d_grant", i), 64'(O_GRANT), 64'(tbl[i].eg));
            chk($sformatf("vec%0d_s00_rdy", i), 64'(s00.tready), 64'(tbl[i].er0));
            chk($sformatf("vec%0d_s01_rdy", i), 64'(s01.tready), 64'(tbl[i].er1));
            chk($sformatf("vec%0d_busy", i), 64'(O_BUSY), 64'(tbl[i].eb));
        end

        // ---- round robin, both continuously valid, 4-beat packets ----
        do_reset();
        src_on[0] = 1'b1; src_on[1] = 1'b1; gap_en = 1'b1;
        drive_src();
        run(30);
        chk("rr_gap_cycles", 64'(gap_cnt), 64'd0);
        chk("rr_beats_enough", 64'(tid_log.size() >= 16), 64'd1);
        for (int k = 0; k < 16 && k < tid_log.size(); k++)
            chk($sformatf("rr_tid%0d", k), 64'(tid_log[k]), 64'((k / 4) % 2));

        // ---- backpressure: m00.tready low 5 cycles mid-stream ----
        do_reset();
        src_on[0] = 1'b1; bp_start = 4; bp_len = 5;
        drive_src();
        run(20);
        src_on[0] = 1'b0;
        drive_src();
        run(6);
        chk("bp_stall_cycles", 64'(stall_cnt), 64'd5);
        chk("bp_q0_drained", 64'(q0.size()), 64'd0);
        chk("bp_beats_out", 64'(tid_log.size()), 64'(idx[0]));

        // ---- I_EN0 dropped after beat 2 of a CNT0 packet ----
        do_reset();
        src_on[0] = 1'b1; src_on[1] = 1'b1; en_drop_at = 2;
        drive_src();
        run(20);
        chk("en_beats_enough", 64'(tid_log.size() >= 12), 64'd1);
        for (int k = 0; k < 12 && k < tid_log.size(); k++)
            chk($sformatf("en_tid%0d", k), 64'(tid_log[k]), 64'(k >= 4));
        chk("en_grant_ch1", 64'(O_GRANT), 64'd2);

        // ---- reset mid-packet ----
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_m_vld", 64'(m00.tvalid), 64'd0);
        chk("midrst_grant", 64'(O_GRANT), 64'd0);
        chk("midrst_busy", 64'(O_BUSY), 64'd0);
        chk("midrst_s01_rdy", 64'(s01.tready), 64'd0);
        Reset = 1'b0;

`ifdef DAQ_ARB_STATS_EN
        // ---- packet counters ----
        do_reset();
        chk("stats_rst_cnt0", 64'(O_PKT_CNT0), 64'd0);
        chk("stats_rst_cnt1", 64'(O_PKT_CNT1), 64'd0);
        pkt_len = 2;
        src_on[0] = 1'b1; src_on[1] = 1'b1;
        src_lim[0] = 6; src_lim[1] = 4;
        drive_src();
        run(20);
        chk("stats_cnt0", 64'(O_PKT_CNT0), 64'd3);
        chk("stats_cnt1", 64'(O_PKT_CNT1), 64'd2);
        @(negedge CLK);
        force dut.pkt_cnt0 = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.pkt_cnt0;
        @(posedge CLK); #1;
        src_lim[0] = 8;
        drive_src();
        run(10);
        chk("stats_wrap_cnt0", 64'(O_PKT_CNT0), 64'd0);
        chk("stats_wrap_cnt1", 64'(O_PKT_CNT1), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/daq_stream_arbiter.md
Name: daq_stream_arbiter

Overview:
Packet-level round-robin arbiter that merges the two DAQ counter result streams (CNT0 on s00_axis, CNT1 on s01_axis) onto one AXI4-Stream master feeding the shared DMA channel. Grants are locked per packet: a grant is held from the first beat until the tlast beat. Beats are tagged with the source channel on tid. The output is a registered slice, so the DMA side sees clean registered outputs.

Parameters:
C_AXIS_TDATA_WIDTH, 64, data width of both slave streams and the master stream; must be a multiple of 8
C_LAST_GRANT_INIT, 1, reset value of the round-robin pointer (1 = channel 0 wins the first tie)

Ports:
CLK  in  1  single clock for all logic
Reset  in  1  synchronous, active-high reset
s00_axis_tvalid  in  1  CNT0 stream valid
s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  CNT0 data
s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  CNT0 byte strobes
s00_axis_tlast  in  1  CNT0 end of packet
s00_axis_tready  out  1  CNT0 ready
s01_axis_tvalid/tdata/tstrb/tlast  in  as s00  CNT1 stream
s01_axis_tready  out  1  CNT1 ready
m00_axis_tvalid  out  1  merged stream valid (registered)
m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  merged data (registered)
m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  merged strobes (registered)
m00_axis_tlast  out  1  merged end of packet (registered)
m00_axis_tid  out  1  source channel of the current beat (0 = CNT0, 1 = CNT1)
m00_axis_tready  in  1  downstream ready
I_EN0  in  1  channel 0 eligible for new grants
I_EN1  in  1  channel 1 eligible for new grants
O_GRANT  out  2  one-hot current grant; 00 = idle
O_BUSY  out  1  high when O_GRANT != 00 or m00_axis_tvalid = 1

Behaviour:
- States: IDLE, GNT0, GNT1. O_GRANT is decoded from the state: IDLE = 00, GNT0 = 01, GNT1 = 10.
- Reset: takes effect on the next CLK edge.
  - State goes to IDLE; last_grant is set to C_LAST_GRANT_INIT.
  - m00_axis_tvalid, tdata, tstrb, tlast, tid and O_BUSY are all 0. Both s*_tready are 0.
  - Reset mid-packet drops the output register contents and the partial packet. No tlast is synthesized.
- Eligibility: req_x = s0x_axis_tvalid & I_ENx.
- Arbitration:
  - Evaluated in IDLE, and in the same cycle as an accepted tlast beat.
  - Only req_x set: next state is GNTx.
  - Both set: grant the channel != last_grant.
  - Neither set: next state is IDLE.
  - When a grant is made, last_grant is updated to the granted channel.
  - There is no bubble between back-to-back packets.
- Output slice: out_free = ~m00_axis_tvalid | m00_axis_tready.
- Ready: s0x_axis_tready = (state == GNTx) & out_free. This is combinational from state and m00_axis_tready. The ungranted channel always sees tready = 0.
- Accepting a beat (s0x_tvalid & s0x_tready):
  - The output register loads tdata, tstrb and tlast; tid = x; m00_axis_tvalid = 1.
  - An output handshake with no new beat clears m00_axis_tvalid.
- Grant release: an accepted tlast beat releases the grant and re-arbitrates that cycle.
- Latency: the first beat appears on the master one cycle after the state enters GNTx and the source is valid. From IDLE to the first output valid takes 2 cycles.
- Throughput: 1 beat/cycle sustained while m00_axis_tready = 1.
- Enables: I_ENx is sampled only at arbitration. Deasserting it mid-packet never truncates the packet. Both enables low leaves the block in IDLE; streams are held with tready = 0.
- Backpressure: m00_axis_tdata, tstrb, tlast and tid are stable while m00_axis_tvalid = 1 and m00_axis_tready = 0.
- Source tvalid low mid-packet: the grant is held and no beat is loaded. No timeout.
- Single-beat packets (tlast on the first beat) are legal and re-arbitrate immediately.

Optional Feature:
- DAQ_ARB_STATS_EN: adds outputs O_PKT_CNT0 and O_PKT_CNT1 (32 bits each).
  - O_PKT_CNTx increments on each master handshake with tlast = 1 and tid = x.
  - Counters wrap 0xFFFFFFFF -> 0 and reset to 0.
  - Both counters may increment in no cycle simultaneously, since only one tid exists per beat.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles with both sources valid -> all outputs 0, both tready 0, O_GRANT = 00; release -> GNT0 first (C_LAST_GRANT_INIT = 1).
- Both channels continuously valid, 4-beat packets, m00_axis_tready = 1 -> tid sequence 0,0,0,0,1,1,1,1,0,... with no idle cycle between packets.
- Only CNT1 valid, data 0x1..0x3 with tlast on 0x3 -> master emits 0x1,0x2,0x3, tid = 1, tlast on the third beat only, first valid 2 cycles after s01_axis_tvalid.
- m00_axis_tready low 5 cycles mid-packet -> held beat stable, s00_axis_tready = 0 for those cycles, no beat lost or duplicated.
- I_EN0 dropped after beat 2 of a 4-beat CNT0 packet -> all 4 beats delivered, then only CNT1 granted; Reset asserted mid-packet -> m00_axis_tvalid = 0 next cycle, O_GRANT = 00.
- DAQ_ARB_STATS_EN defined, 3 CNT0 and 2 CNT1 packets -> O_PKT_CNT0 = 3, O_PKT_CNT1 = 2; preload via 2^32-1 packets (or force) -> wraps to 0.
